// File: rtl/xiphos_pkg.sv
// ---------------------------------------------------------------------------
// xiphos_pkg
// Shared constants and types for the program-counter front end.
//   XLEN       : PC width in bits
//   RESET_VEC  : PC loaded on reset (word aligned)
//   INC        : sequential PC increment in bytes
//   CNT_W      : width of the issued-PC counter
//   pc_state_e : sequencer FSM states
// ---------------------------------------------------------------------------
package xiphos_pkg;

    localparam int unsigned XLEN      = 32;
    localparam logic [31:0] RESET_VEC = 32'h0000_0000;
    localparam int unsigned INC       = 4;
    localparam int unsigned CNT_W     = 16;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_e;

    // A redirect target is usable only when it is word aligned.
    function automatic logic is_aligned(input logic [1:0] lsbs);
        return lsbs == 2'b00;
    endfunction

endpackage : xiphos_pkg

// File: rtl/next_pc_mux.sv
// ---------------------------------------------------------------------------
// next_pc_mux
// Combinational 2:1 next-PC selector.
//   x   : in  W  sequential candidate (pc + INC)
//   y   : in  W  redirect candidate
//   sel : in  1  0 selects x, 1 selects y
//   out : out W  selected next PC
// ---------------------------------------------------------------------------
module next_pc_mux #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         sel,
    output logic [W-1:0] out
);

    assign out = sel ? y : x;

endmodule : next_pc_mux

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
// Program-counter stage: issues PCs to fetch over valid/ready, follows
// aligned redirects, supports halt/resume and drops misaligned redirects.
//   clk             : in  1      system clock, rising edge
//   rst_n           : in  1      asynchronous active-low reset
//   redirect_valid  : in  1      redirect request (single-cycle pulse)
//   redirect_target : in  XLEN   redirect destination
//   halt            : in  1      stop issuing PCs (level)
//   pc_ready        : in  1      fetch accepts pc this cycle
//   pc_valid        : out 1      pc is valid for fetch
//   pc              : out XLEN   current program counter
//   next_sel        : out 1      mux select (combinational): 1 = redirect
//   misalign_err    : out 1      pulse: a misaligned redirect was dropped
//   issue_count     : out CNT_W  accepted PCs, wraps
// ---------------------------------------------------------------------------
module pc_sequencer #(
    parameter int unsigned XLEN      = xiphos_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(xiphos_pkg::RESET_VEC),
    parameter int unsigned INC       = xiphos_pkg::INC,
    parameter int unsigned CNT_W     = xiphos_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_target,
    input  logic             halt,
    input  logic             pc_ready,
    output logic             pc_valid,
    output logic [XLEN-1:0]  pc,
    output logic             next_sel,
    output logic             misalign_err,
    output logic [CNT_W-1:0] issue_count
);

    import xiphos_pkg::*;

    pc_state_e       state;
    pc_state_e       state_next;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] pc_inc;
    logic [XLEN-1:0] mux_out;
    logic            valid_next;
    logic            aligned;
    logic            misaligned;
    logic            accept;

    // Next-PC candidate selection: sequential vs. redirect target.
    next_pc_mux #(
        .W (XLEN)
    ) u_next_pc_mux (
        .x   (pc_inc),
        .y   (redirect_target),
        .sel (next_sel),
        .out (mux_out)
    );

    // Decoded handshake and redirect qualifiers; a misaligned redirect never
    // steers the mux, so the rest of the logic sees it as no redirect at all.
    always_comb begin
        aligned    = redirect_valid && is_aligned(redirect_target[1:0]);
        misaligned = redirect_valid && !aligned;
        next_sel   = aligned;
        accept     = pc_valid && pc_ready;
        pc_inc     = pc + XLEN'(INC);
    end

    // Next-state and next-PC logic.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        valid_next = 1'b0;
        case (state)
            BOOT: begin
                state_next = RUN;
                if (aligned) begin
                    pc_next = mux_out;
                end
            end
            RUN: begin
                // Redirect wins over an unaccepted PC; mux already picks it.
                if (aligned || accept) begin
                    pc_next = mux_out;
                end
                if (halt) begin
                    state_next = HALT;
                end
            end
            HALT: begin
                if (aligned) begin
                    pc_next = mux_out;
                end
                if (!halt) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase
        valid_next = (state_next == RUN);
    end

    // State, PC, valid, counter and error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= BOOT;
            pc           <= RESET_VEC;
            pc_valid     <= 1'b0;
            issue_count  <= '0;
            misalign_err <= 1'b0;
        end else begin
            state        <= state_next;
            pc           <= pc_next;
            pc_valid     <= valid_next;
            misalign_err <= misaligned;
            if (accept) begin
                issue_count <= issue_count + CNT_W'(1);
            end
        end
    end

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
// Directed stimulus with a scoreboard: each expected accepted (pc, count)
// pair is queued by the stimulus; a monitor pops and compares on every
// accepted handshake. Register state is also checked directly at key points.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt;
    logic        pc_ready;
    logic        pc_valid;
    logic [31:0] pc;
    logic        next_sel;
    logic        misalign_err;
    logic [15:0] issue_count;

    typedef struct packed {
        logic [31:0] pc;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   vectors     = 0;
    int   miscompares = 0;

    pc_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt            (halt),
        .pc_ready        (pc_ready),
        .pc_valid        (pc_valid),
        .pc              (pc),
        .next_sel        (next_sel),
        .misalign_err    (misalign_err),
        .issue_count     (issue_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] p, input logic [15:0] c);
        exp_q.push_back({p, c});
    endtask

    task automatic do_reset(input logic rdy);
        rst_n           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        halt            = 1'b0;
        pc_ready        = rdy;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor: compares every accepted handshake.
    always @(negedge clk) begin
        if (rst_n && pc_valid && pc_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_accept: got pc %08h expected no accept at %0t", pc, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("accept_pc", pc, mon_e.pc);
                check("accept_count", 32'(issue_count), 32'(mon_e.cnt));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1. Boot and sequential issue.
        do_reset(1'b1);
        check("boot_valid", 32'(pc_valid), 32'd0);
        check("boot_pc", pc, 32'h0);
        check("boot_count", 32'(issue_count), 32'd0);
        check("boot_err", 32'(misalign_err), 32'd0);
        push(32'h0, 16'd0);
        push(32'h4, 16'd1);
        push(32'h8, 16'd2);
        push(32'hC, 16'd3);
        step();
        check("run_valid", 32'(pc_valid), 32'd1);
        step();
        step();
        step();
        check("seq_pc_c", pc, 32'hC);
        check("seq_count3", 32'(issue_count), 32'd3);
        step();
        pc_ready = 1'b0;

        // 2. Stall holds pc, release advances.
        do_reset(1'b1);
        push(32'h0, 16'd0);
        push(32'h4, 16'd1);
        step();
        step();
        step();
        pc_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall_pc", pc, 32'h8);
            check("stall_valid", 32'(pc_valid), 32'd1);
            if (i < 2) step();
        end
        step();
        push(32'h8, 16'd2);
        pc_ready = 1'b1;
        step();
        pc_ready = 1'b0;
        check("release_pc", pc, 32'hC);
        check("release_count", 32'(issue_count), 32'd3);

        // 3. Redirect while stalled; 4. misaligned redirect dropped.
        do_reset(1'b1);
        push(32'h0, 16'd0);
        push(32'h4, 16'd1);
        step();
        step();
        step();
        pc_ready        = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h100;
        #1;
        check("sel_aligned", 32'(next_sel), 32'd1);
        step();
        check("redir_pc", pc, 32'h100);
        check("redir_count", 32'(issue_count), 32'd2);
        check("redir_err", 32'(misalign_err), 32'd0);
        pc_ready        = 1'b1;
        redirect_target = 32'h102;
        push(32'h100, 16'd2);
        #1;
        check("sel_misaligned", 32'(next_sel), 32'd0);
        step();
        redirect_valid = 1'b0;
        check("misalign_err_set", 32'(misalign_err), 32'd1);
        check("misalign_pc", pc, 32'h104);
        push(32'h104, 16'd3);
        step();
        check("misalign_err_clear", 32'(misalign_err), 32'd0);
        check("seq_after_misalign", pc, 32'h108);

        // 5. Halt, then redirect-resume.
        push(32'h108, 16'd4);
        halt = 1'b1;
        step();
        check("halt_valid", 32'(pc_valid), 32'd0);
        check("halt_pc", pc, 32'h10C);
        check("halt_count", 32'(issue_count), 32'd5);
        step();
        check("halt_hold_valid", 32'(pc_valid), 32'd0);
        check("halt_hold_pc", pc, 32'h10C);
        halt            = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h200;
        step();
        check("resume_valid", 32'(pc_valid), 32'd1);
        check("resume_pc", pc, 32'h200);

        // 6. Wrap at top of address space, then reset mid-stall.
        redirect_target = 32'hFFFF_FFFC;
        push(32'h200, 16'd5);
        step();
        redirect_valid = 1'b0;
        check("top_pc", pc, 32'hFFFF_FFFC);
        push(32'hFFFF_FFFC, 16'd6);
        step();
        check("wrap_pc", pc, 32'h0);
        push(32'h0, 16'd7);
        step();
        pc_ready = 1'b0;
        check("post_wrap_pc", pc, 32'h4);
        check("post_wrap_count", 32'(issue_count), 32'd8);
        step();
        check("prereset_pc", pc, 32'h4);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_pc", pc, 32'h0);
        check("midreset_valid", 32'(pc_valid), 32'd0);
        check("midreset_count", 32'(issue_count), 32'd0);
        step();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_pc_sequencer
